fifo_frame_param: RTL and testbench
===================================

// Module: fifo_frame_param
// PURPOSE
//  Parametrised circular-buffer frame FIFO that replaces the fixed 128x32 shift-register FIFO between the sample path and the FFT engine.
//  - Depth and width are generic; storage uses pointers instead of a shift chain.
//  - Reads are first-word-fall-through (FWFT).
//  - Adds simultaneous read/write, empty/almost-full flags, a live occupancy count, a frame-ready pulse and sticky overflow/underflow errors.
// PARAMETERS
//  DWIDTH      32    data word width, bits
//  DEPTH       128   words per frame; power of two, >= 4
//  AFULL_LVL   120   almost_full asserts when count >= AFULL_LVL; 1..DEPTH
// PORTS
//  clk          in   1           clock, rising edge
//  n_rst        in   1           asynchronous reset, active low
//  clr          in   1           synchronous flush, e.g. FFT done; highest priority
//  err_clr      in   1           synchronous clear of the sticky error flags
//  wr_ce        in   1           write strobe
//  data_in      in   DWIDTH      write data
//  rd_ce        in   1           read/pop strobe
//  data_out     out  DWIDTH      oldest word (FWFT); 0 when empty
//  count        out  AW+1        occupancy 0..DEPTH; AW = $clog2(DEPTH)
//  empty        out  1           count == 0
//  full         out  1           count == DEPTH
//  almost_full  out  1           count >= AFULL_LVL
//  frame_rdy    out  1           1-cycle pulse: count reached DEPTH
//  ovf_err      out  1           sticky: a write was dropped while full
//  udf_err      out  1           sticky: a read was issued while empty
// BEHAVIOUR
//  Reset (n_rst=0, async)
//   - wr_ptr = rd_ptr = 0, count = 0.
//   - frame_rdy, ovf_err, udf_err = 0; empty = 1; full = almost_full = 0; data_out = 0.
//   - Memory array is not reset.
//  State and flags
//   - Registered state: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], frame_rdy, ovf_err, udf_err.
//   - empty, full and almost_full decode combinationally from the registered count, so they have zero latency relative to count.
//   - data_out = empty ? 0 : mem[rd_ptr]; combinational read, valid in the same cycle the word becomes oldest.
//  Write
//   - Accepted when wr_ce=1 and (!full or rd_ce=1).
//   - mem[wr_ptr] <= data_in; wr_ptr increments and wraps DEPTH-1 -> 0 naturally.
//  Read
//   - Accepted when rd_ce=1 and !empty.
//   - rd_ptr increments and wraps; the popped word is no longer visible next cycle.
//  Count update
//   - Write only: count + 1. Read only: count - 1.
//   - Both accepted: count unchanged. Neither accepted: count unchanged.
//  Boundaries
//   - Full, wr_ce=1, rd_ce=0: write dropped, ovf_err <= 1, no state change.
//   - Full, wr_ce=1, rd_ce=1: both accepted, count stays DEPTH.
//   - Empty, rd_ce=1, wr_ce=0: read ignored, udf_err <= 1.
//   - Empty, rd_ce=1, wr_ce=1: write accepted, read ignored, udf_err <= 1, count -> 1.
//  Clear
//   - clr=1: next cycle wr_ptr = rd_ptr = 0 and count = 0; wr_ce and rd_ce in that cycle are ignored.
//   - clr does not set or clear the error flags.
//  Error flags
//   - err_clr=1 clears ovf_err and udf_err next cycle.
//   - If an error event coincides with err_clr, the set wins.
//  frame_rdy
//   - Registered; high for exactly one cycle, in the cycle after count goes from DEPTH-1 to DEPTH.
//   - Not re-issued while count stays at DEPTH.
//   - Forced to 0 on clr.
//  Reset mid-operation: all state returns to reset values immediately; any in-flight frame is lost.
// TESTING
//  1. Reset, then 128 writes of 0..127 -> count=128, full=1, frame_rdy pulses 1 cycle after the 128th write, almost_full from count=120, data_out=0.
//  2. From full, 128 reads -> data_out sequence 0..127 in order, empty=1 after the last read, data_out=0, no errors.
//  3. Fill to 128 then write 0xDEAD -> ovf_err=1, count=128, data_out=0; err_clr -> ovf_err=0.
//  4. Fill 64, then 300 cycles with wr_ce=rd_ce=1 -> count stays 64, output order preserved across pointer wrap, udf_err=0.
//  5. Empty FIFO, rd_ce=wr_ce=1 with 0x1234 -> udf_err=1, count=1, data_out=0x1234 next cycle.
//  6. Fill 50, assert clr with wr_ce=1 -> count=0, empty=1; assert n_rst mid-fill -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_frame_param.sv
// Circular-buffer frame FIFO with first-word-fall-through reads, occupancy flags,
// a frame-complete pulse and sticky overflow/underflow errors.
module fifo_frame_param #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 128,
  parameter int AFULL_LVL = 120,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              err_clr,
  input  logic              wr_ce,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_ce,
  output logic [DWIDTH-1:0] data_out,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              frame_rdy,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          frame_rdy_q, frame_rdy_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;
  assign frame_rdy   = frame_rdy_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;
  assign data_out    = empty ? '0 : mem_q[rd_ptr_q];

  // Strobe semantics: wr_ce/rd_ce are single-cycle requests with no back-pressure.
  // A write completes in the cycle wr_ce is high if the FIFO is not full or a read
  // frees a slot in that same cycle; a read completes when rd_ce is high and the
  // FIFO is not empty. Refused requests are dropped and flagged as errors.
  assign wr_acc = !clr && wr_ce && (!full || rd_ce);
  assign rd_acc = !clr && rd_ce && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_rdy_d = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      frame_rdy_d = (count_q == LAST_C) && wr_acc && !rd_acc;
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (!clr && wr_ce && full && !rd_ce) ovf_d = 1'b1;
    if (!clr && rd_ce && empty)          udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_rdy_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_rdy_q <= frame_rdy_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_frame_param.sv
// Scenario bench for fifo_frame_param: fill/drain, overflow, streaming wrap,
// underflow, clear and asynchronous reset, checked against a data queue.
module tb_fifo_frame_param;

  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int AFULL = 120;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          n_rst;
  logic          clr;
  logic          err_clr;
  logic          wr_ce;
  logic [DW-1:0] data_in;
  logic          rd_ce;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          frame_rdy;
  logic          ovf_err;
  logic          udf_err;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int            checks;
  int            errors;

  fifo_frame_param #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .n_rst(n_rst), .clr(clr), .err_clr(err_clr),
    .wr_ce(wr_ce), .data_in(data_in), .rd_ce(rd_ce),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .frame_rdy(frame_rdy),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present strobes for one cycle, return 1 time unit after the edge
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic ec);
    wr_ce   = w;
    data_in = d;
    rd_ce   = r;
    clr     = c;
    err_clr = ec;
    @(posedge clk);
    #1;
    wr_ce   = 1'b0;
    rd_ce   = 1'b0;
    clr     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    exp_q.push_back(d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    exp_q.delete();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #3;
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        frame_rdy !== 1'b0 || ovf_err !== 1'b0 || udf_err !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b af=%b fr=%b ovf=%b udf=%b do=%0h exp cnt=0 e=1 rest 0",
               count, empty, full, almost_full, frame_rdy, ovf_err, udf_err, data_out);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      push(DW'(i));
      checks++;
      if (count !== (AW+1)'(i + 1) || almost_full !== ((i + 1) >= AFULL) ||
          frame_rdy !== (i == DEPTH - 1) || full !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL fill_step%0d got cnt=%0d af=%b fr=%b f=%b exp cnt=%0d af=%b fr=%b f=%b",
                 i, count, almost_full, frame_rdy, full, i + 1, (i + 1) >= AFULL,
                 i == DEPTH - 1, i == DEPTH - 1);
      end
    end
    checks++;
    if (data_out !== 32'd0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_head got do=%0h e=%b exp do=0 e=0", data_out, empty);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_rdy !== 1'b0 || count !== (AW+1)'(DEPTH)) begin
      errors++;
      $display("FAIL frame_rdy_once got fr=%b cnt=%0d exp fr=0 cnt=%0d", frame_rdy, count, DEPTH);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (data_out !== exp_w) begin
        errors++;
        $display("FAIL drain_word%0d got %0h exp %0h", i, data_out, exp_w);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || data_out !== '0 || count !== '0 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      errors++;
      $display("FAIL drain_end got e=%b do=%0h cnt=%0d ovf=%b udf=%b exp e=1 do=0 cnt=0 ovf=0 udf=0",
               empty, data_out, count, ovf_err, udf_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) push(DW'(i));
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf_err !== 1'b1 || count !== (AW+1)'(DEPTH) || data_out !== exp_q[0]) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b cnt=%0d do=%0h exp ovf=1 cnt=%0d do=%0h",
               ovf_err, count, data_out, DEPTH, exp_q[0]);
    end
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins got %b exp 1", ovf_err);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err_clr got %b exp 0", ovf_err);
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (data_out !== exp_w) begin
      errors++;
      $display("FAIL full_rw_head got %0h exp %0h", data_out, exp_w);
    end
    exp_q.push_back(32'hCAFE);
    drive(1'b1, 32'hCAFE, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== (AW+1)'(DEPTH) || ovf_err !== 1'b0 || frame_rdy !== 1'b0 || data_out !== exp_q[0]) begin
      errors++;
      $display("FAIL full_rw got cnt=%0d ovf=%b fr=%b do=%0h exp cnt=%0d ovf=0 fr=0 do=%0h",
               count, ovf_err, frame_rdy, data_out, DEPTH, exp_q[0]);
    end
    drive(1'b1, 32'h5555, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    checks++;
    if (count !== '0 || empty !== 1'b1 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL clr_keeps_err got cnt=%0d e=%b ovf=%b exp cnt=0 e=1 ovf=1", count, empty, ovf_err);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) push(DW'($urandom));
    for (int i = 0; i < 300; i++) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (data_out !== exp_w) begin
        errors++;
        $display("FAIL stream_word%0d got %0h exp %0h", i, data_out, exp_w);
      end
      exp_w = DW'($urandom);
      exp_q.push_back(exp_w);
      drive(1'b1, exp_w, 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== (AW+1)'(64)) begin
        errors++;
        $display("FAIL stream_count%0d got %0d exp 64", i, count);
      end
    end
    checks++;
    if (udf_err !== 1'b0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_errs got ovf=%b udf=%b exp 0 0", ovf_err, udf_err);
    end
    flush();
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (udf_err !== 1'b1 || count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL udf_read got udf=%b cnt=%0d e=%b exp udf=1 cnt=0 e=1", udf_err, count, empty);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (udf_err !== 1'b0) begin
      errors++;
      $display("FAIL udf_err_clr got %b exp 0", udf_err);
    end
    exp_q.push_back(32'h1234);
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
    checks++;
    if (udf_err !== 1'b1 || count !== (AW+1)'(1) || data_out !== exp_q[0]) begin
      errors++;
      $display("FAIL udf_rw got udf=%b cnt=%0d do=%0h exp udf=1 cnt=1 do=%0h",
               udf_err, count, data_out, exp_q[0]);
    end
    flush();
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 50; i++) push(DW'($urandom_range(1, 32'hFFFF)));
    drive(1'b1, 32'h7777, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    checks++;
    if (count !== '0 || empty !== 1'b1 || data_out !== '0 || frame_rdy !== 1'b0) begin
      errors++;
      $display("FAIL clr_flush got cnt=%0d e=%b do=%0h fr=%b exp cnt=0 e=1 do=0 fr=0",
               count, empty, data_out, frame_rdy);
    end
    for (int i = 0; i < 30; i++) push(DW'($urandom_range(1, 32'hFFFF)));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        frame_rdy !== 1'b0 || ovf_err !== 1'b0 || udf_err !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d e=%b f=%b af=%b fr=%b ovf=%b udf=%b do=%0h exp cnt=0 e=1 rest 0",
               count, empty, full, almost_full, frame_rdy, ovf_err, udf_err, data_out);
    end
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    push(32'hA5A5);
    checks++;
    if (data_out !== exp_q[0] || count !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL post_reset_write got do=%0h cnt=%0d exp do=%0h cnt=1", data_out, count, exp_q[0]);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr     = 1'b0;
    err_clr = 1'b0;
    wr_ce   = 1'b0;
    rd_ce   = 1'b0;
    data_in = '0;
    n_rst   = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
